// File: rtl/game_io_pkg.sv
// Shared constants and types for the game input controller: jal encoding,
// instruction field widths, FSM state type and default ISR targets.
package game_io_pkg;
    localparam int OPC_W   = 5;
    localparam int TGT_W   = 27;
    localparam int INSTR_W = OPC_W + TGT_W;

    localparam logic [OPC_W-1:0] OPC_JAL       = 5'b00011;
    localparam logic [TGT_W-1:0] JUMP_ISR_DEF  = 27'd100;
    localparam logic [TGT_W-1:0] FRAME_ISR_DEF = 27'd200;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    function automatic logic [INSTR_W-1:0] make_jal(input logic [TGT_W-1:0] target);
        return {OPC_JAL, target};
    endfunction
endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus debouncer for a raw push-button; emits a
// one-cycle pulse one cycle after the debounced level rises.
module input_debouncer #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_dly_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_d;

    // The count only advances while the synced input disagrees with the
    // accepted level, so any bounce back restarts it from zero.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            level_dly_q <= level_q;
            rise_q      <= level_q & ~level_dly_q;
        end
    end

    assign rise_o = rise_q;
endmodule

// File: rtl/game_input_controller.sv
// Turns the debounced jump button and a frame tick into jal interrupt
// instructions, one at a time, under a valid/ack/done handshake.
module game_input_controller
    import game_io_pkg::*;
#(
    parameter int                CLK_FREQ       = 100_000_000,
    parameter int                FRAME_RATE     = 60,
    parameter int                DEBOUNCE_CYC   = 1_000_000,
    parameter logic [TGT_W-1:0]  JUMP_ISR_ADDR  = JUMP_ISR_DEF,
    parameter logic [TGT_W-1:0]  FRAME_ISR_ADDR = FRAME_ISR_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               jump,
    input  logic               int_ack,
    input  logic               int_done,
    output logic [INSTR_W-1:0] interrupt_instruction,
    output logic               int_valid,
    output logic               frame_tick,
    output logic [7:0]         dropped_frames
);
    localparam int FRAME_DIV = CLK_FREQ / FRAME_RATE;
    localparam int FW        = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);

    logic               jump_rise;
    logic [FW-1:0]      frame_cnt_q;
    logic               jump_pend_q, jump_pend_d;
    logic               frame_pend_q, frame_pend_d;
    logic [7:0]         dropped_q, dropped_d;
    logic               ack_hit, jump_clr, frame_clr;
    state_t             state_q;
    logic               issued_jump_q;
    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;

    input_debouncer #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_jump_db (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (jump),
        .rise_o (jump_rise)
    );

    assign frame_tick = (frame_cnt_q == FRAME_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (frame_tick) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_q + FW'(1);
        end
    end

    // A new event wins over the clear of its own flag, so it is neither lost
    // nor counted as dropped.
    always_comb begin
        ack_hit      = (state_q == ISSUE) && int_ack;
        jump_clr     = ack_hit && issued_jump_q;
        frame_clr    = ack_hit && !issued_jump_q;
        jump_pend_d  = jump_rise | (jump_pend_q & ~jump_clr);
        frame_pend_d = frame_tick | (frame_pend_q & ~frame_clr);
        dropped_d    = dropped_q;
        if (frame_tick && frame_pend_q && !frame_clr && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jump_pend_q  <= 1'b0;
            frame_pend_q <= 1'b0;
            dropped_q    <= '0;
        end else begin
            jump_pend_q  <= jump_pend_d;
            frame_pend_q <= frame_pend_d;
            dropped_q    <= dropped_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            issued_jump_q <= 1'b0;
            valid_q       <= 1'b0;
            instr_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (jump_pend_q) begin
                        state_q       <= ISSUE;
                        issued_jump_q <= 1'b1;
                        valid_q       <= 1'b1;
                        instr_q       <= make_jal(JUMP_ISR_ADDR);
                    end else if (frame_pend_q) begin
                        state_q       <= ISSUE;
                        issued_jump_q <= 1'b0;
                        valid_q       <= 1'b1;
                        instr_q       <= make_jal(FRAME_ISR_ADDR);
                    end
                end
                ISSUE: begin
                    if (int_ack) begin
                        state_q <= BUSY;
                        valid_q <= 1'b0;
                        instr_q <= '0;
                    end
                end
                BUSY: begin
                    if (int_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign interrupt_instruction = instr_q;
    assign int_valid             = valid_q;
    assign dropped_frames        = dropped_q;
endmodule

// File: tb/tb_game_input_controller.sv
// Bench for game_input_controller: directed scenarios plus random button and
// handshake traffic, compared against an event-level reference model.
`timescale 1ns/1ps
module tb_game_input_controller;
    localparam int CLK_FREQ   = 1000;
    localparam int FRAME_RATE = 10;
    localparam int DEB        = 4;
    localparam int FDIV       = CLK_FREQ / FRAME_RATE;
    localparam logic [31:0] JAL_JUMP  = 32'h1800_0064;
    localparam logic [31:0] JAL_FRAME = 32'h1800_00C8;

    logic        clk = 1'b0;
    logic        reset, jump, int_ack, int_done;
    logic [31:0] interrupt_instruction;
    logic        int_valid, frame_tick;
    logic [7:0]  dropped_frames;
    int          total = 0;
    int          bad   = 0;

    game_input_controller #(
        .CLK_FREQ     (CLK_FREQ),
        .FRAME_RATE   (FRAME_RATE),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .jump                  (jump),
        .int_ack               (int_ack),
        .int_done              (int_done),
        .interrupt_instruction (interrupt_instruction),
        .int_valid             (int_valid),
        .frame_tick            (frame_tick),
        .dropped_frames        (dropped_frames)
    );

    always #5 clk = ~clk;

    // Reference model: m_c counts clock edges since reset release.
    int          m_c;
    bit          m_q[$];
    bit          m_level;
    int          m_run;
    int          m_jset_at;
    bit          m_jp, m_fp, m_isj;
    int          m_phase;          // 0 waiting, 1 request out, 2 handler running
    logic [7:0]  m_drop;
    logic        m_valid, m_tick;
    logic [31:0] m_instr;

    task automatic model_outputs();
        m_valid = (m_phase == 1);
        m_instr = m_valid ? (m_isj ? JAL_JUMP : JAL_FRAME) : 32'd0;
        m_tick  = ((m_c % FDIV) == FDIV - 1);
    endtask

    task automatic model_reset();
        m_c = 0; m_q.delete(); m_level = 0; m_run = 0; m_jset_at = -1;
        m_jp = 0; m_fp = 0; m_isj = 0; m_phase = 0; m_drop = 8'd0;
        model_outputs();
    endtask

    task automatic model_step();
        bit d, jset, fset, clr_j, clr_f;
        if (reset) begin
            model_reset();
            return;
        end
        m_c++;
        d = (m_q.size() == 2) ? m_q[0] : 1'b0;
        m_q.push_back(jump);
        if (m_q.size() > 2) void'(m_q.pop_front());
        jset = (m_c == m_jset_at);
        fset = ((m_c % FDIV) == 0);
        if (d != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                m_level = d;
                m_run   = 0;
                if (d) m_jset_at = m_c + 2;
            end
        end else begin
            m_run = 0;
        end
        clr_j = (m_phase == 1) && int_ack && m_isj;
        clr_f = (m_phase == 1) && int_ack && !m_isj;
        if (fset && m_fp && !clr_f && m_drop < 8'd255) m_drop++;
        case (m_phase)
            0: if (m_jp) begin m_phase = 1; m_isj = 1; end
               else if (m_fp) begin m_phase = 1; m_isj = 0; end
            1: if (int_ack) m_phase = 2;
            default: if (int_done) m_phase = 0;
        endcase
        m_jp = jset || (m_jp && !clr_j);
        m_fp = fset || (m_fp && !clr_f);
        model_outputs();
    endtask

    function automatic logic [41:0] dut_vec();
        return {int_valid, frame_tick, dropped_frames, interrupt_instruction};
    endfunction

    function automatic logic [41:0] mdl_vec();
        return {m_valid, m_tick, m_drop, m_instr};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; jump = 1'b0; int_ack = 1'b0; int_done = 1'b0;
        model_reset();
        repeat (3) step();
        total++; if (interrupt_instruction !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h want=0", interrupt_instruction); end
        total++; if (int_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", int_valid); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
        total++; if (dropped_frames !== 8'd0) begin bad++; $display("FAIL reset_dropped got=%0d want=0", dropped_frames); end
        reset = 1'b0;
    endtask

    task automatic test_frame_issue();
        int tick_at  = -1;
        int valid_at = -1;
        for (int i = 1; i <= 120; i++) begin
            step();
            total++; if (dut_vec() !== mdl_vec()) begin bad++; $display("FAIL frame_trace cyc=%0d got=%h want=%h", m_c, dut_vec(), mdl_vec()); end
            if (frame_tick && tick_at < 0) tick_at = i;
            if (int_valid && valid_at < 0) valid_at = i;
        end
        total++; if (tick_at != FDIV - 1) begin bad++; $display("FAIL first_tick got=%0d want=%0d", tick_at, FDIV - 1); end
        total++; if (valid_at != FDIV + 1) begin bad++; $display("FAIL frame_issue_cycle got=%0d want=%0d", valid_at, FDIV + 1); end
        total++; if (interrupt_instruction !== JAL_FRAME) begin bad++; $display("FAIL frame_instr got=%h want=%h", interrupt_instruction, JAL_FRAME); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        total++; if ({int_valid, interrupt_instruction} !== 33'd0) begin bad++; $display("FAIL frame_ack got v=%b i=%h want v=0 i=0", int_valid, interrupt_instruction); end
        repeat (3) step();
        int_done = 1'b1; step(); int_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (dut_vec() !== mdl_vec() || int_valid !== 1'b0) begin bad++; $display("FAIL frame_after_done got=%h want=%h", dut_vec(), mdl_vec()); end
        end
    endtask

    task automatic test_debounce();
        int  jump_issues = 0;
        bit  prev_valid  = 0;
        for (int i = 0; i < 45; i++) begin
            jump     = (i < 3) || (i >= 6 && i < 9) || (i >= 12 && i < 22);
            int_ack  = int_valid;
            int_done = (i % 4 == 3);
            step();
            total++; if (dut_vec() !== mdl_vec()) begin bad++; $display("FAIL debounce_trace i=%0d got=%h want=%h", i, dut_vec(), mdl_vec()); end
            if (int_valid && !prev_valid && interrupt_instruction === JAL_JUMP) jump_issues++;
            prev_valid = int_valid;
        end
        int_ack = 1'b0; int_done = 1'b0; jump = 1'b0;
        total++; if (jump_issues != 1) begin bad++; $display("FAIL debounce_count got=%0d want=1", jump_issues); end
    endtask

    task automatic test_simultaneous();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            if ((m_c % FDIV) == FDIV - 8) begin ok = 1; break; end
            int_ack = int_valid; int_done = !int_valid;
            step();
        end
        int_ack = 1'b0; int_done = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL simul_align got=timeout want=aligned"); end
        jump = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (dut_vec() !== mdl_vec()) begin bad++; $display("FAIL simul_trace got=%h want=%h", dut_vec(), mdl_vec()); end
        end
        jump = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (int_valid) begin ok = 1; break; end
            step();
        end
        total++; if (!ok || interrupt_instruction !== JAL_JUMP) begin bad++; $display("FAIL simul_first got v=%b i=%h want v=1 i=%h", int_valid, interrupt_instruction, JAL_JUMP); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        step();
        int_done = 1'b1; step(); int_done = 1'b0;
        total++; if (int_valid !== 1'b0) begin bad++; $display("FAIL simul_gap got=%b want=0", int_valid); end
        step();
        total++; if ({int_valid, interrupt_instruction} !== {1'b1, JAL_FRAME}) begin bad++; $display("FAIL simul_second got v=%b i=%h want v=1 i=%h", int_valid, interrupt_instruction, JAL_FRAME); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        int_done = 1'b1; step(); int_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (dut_vec() !== mdl_vec()) begin bad++; $display("FAIL simul_tail got=%h want=%h", dut_vec(), mdl_vec()); end
        end
    endtask

    task automatic test_withhold();
        bit ok = 0;
        int rises = 0;
        bit prev_valid = 0;
        for (int i = 0; i < 150; i++) begin
            if (int_valid) begin ok = 1; break; end
            step();
        end
        total++; if (!ok) begin bad++; $display("FAIL withhold_wait got valid=0 want valid=1 within 150 cycles"); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        for (int i = 0; i < 350; i++) begin
            step();
            total++; if (dut_vec() !== mdl_vec()) begin bad++; $display("FAIL withhold_trace got=%h want=%h", dut_vec(), mdl_vec()); end
        end
        total++; if (dropped_frames !== 8'd2) begin bad++; $display("FAIL withhold_dropped got=%0d want=2", dropped_frames); end
        int_done = 1'b1; step(); int_done = 1'b0;
        step();
        total++; if ({int_valid, interrupt_instruction} !== {1'b1, JAL_FRAME}) begin bad++; $display("FAIL withhold_reissue got v=%b i=%h want v=1 i=%h", int_valid, interrupt_instruction, JAL_FRAME); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        int_done = 1'b1; step(); int_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (int_valid && !prev_valid) rises++;
            prev_valid = int_valid;
        end
        total++; if (rises != 0) begin bad++; $display("FAIL withhold_single got extra=%0d want extra=0", rises); end
    endtask

    task automatic test_reset_mid();
        bit ok = 0;
        int rises = 0;
        for (int i = 0; i < 150; i++) begin
            if (int_valid) begin ok = 1; break; end
            step();
        end
        total++; if (!ok) begin bad++; $display("FAIL rstmid_wait got valid=0 want valid=1 within 150 cycles"); end
        reset = 1'b1;
        #1;
        total++; if ({int_valid, interrupt_instruction, dropped_frames} !== 41'd0) begin bad++; $display("FAIL rstmid_async got v=%b i=%h d=%0d want all 0", int_valid, interrupt_instruction, dropped_frames); end
        model_reset();
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            total++; if (dut_vec() !== mdl_vec()) begin bad++; $display("FAIL rstmid_trace got=%h want=%h", dut_vec(), mdl_vec()); end
            if (int_valid) rises++;
        end
        total++; if (rises != 0) begin bad++; $display("FAIL rstmid_replay got=%0d valid cycles want=0", rises); end
    endtask

    task automatic test_spurious();
        bit ok = 0;
        int_ack = 1'b1; step(); int_ack = 1'b0;
        total++; if (dut_vec() !== mdl_vec() || int_valid !== 1'b0) begin bad++; $display("FAIL spur_ack_idle got=%h want=%h", dut_vec(), mdl_vec()); end
        for (int i = 0; i < 150; i++) begin
            if (int_valid) begin ok = 1; break; end
            step();
        end
        total++; if (!ok) begin bad++; $display("FAIL spur_wait got valid=0 want valid=1 within 150 cycles"); end
        int_done = 1'b1; step(); int_done = 1'b0;
        step();
        total++; if ({int_valid, interrupt_instruction} !== {1'b1, JAL_FRAME}) begin bad++; $display("FAIL spur_done_issue got v=%b i=%h want v=1 i=%h", int_valid, interrupt_instruction, JAL_FRAME); end
        int_ack = 1'b1; step(); int_ack = 1'b0;
        int_done = 1'b1; step(); int_done = 1'b0;
    endtask

    task automatic test_random();
        int seg_left = 0;
        bit lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if (seg_left == 0) begin
                lvl      = ~lvl;
                seg_left = $urandom_range(1, 8);
            end
            seg_left--;
            jump     = lvl;
            int_ack  = ($urandom_range(0, 2) == 0);
            int_done = ($urandom_range(0, 5) == 0);
            step();
            total++; if (dut_vec() !== mdl_vec()) begin bad++; $display("FAIL random_trace cyc=%0d got=%h want=%h", m_c, dut_vec(), mdl_vec()); end
        end
        jump = 1'b0; int_ack = 1'b0; int_done = 1'b0;
    endtask

    task automatic test_saturate();
        int_ack = 1'b1; int_done = 1'b0; jump = 1'b0;
        for (int i = 0; i < 27000; i++) begin
            step();
            total++; if (dut_vec() !== mdl_vec()) begin bad++; $display("FAIL saturate_trace cyc=%0d got=%h want=%h", m_c, dut_vec(), mdl_vec()); end
        end
        int_ack = 1'b0;
        total++; if (dropped_frames !== 8'd255) begin bad++; $display("FAIL saturate_value got=%0d want=255", dropped_frames); end
    endtask

    initial begin
        test_reset();
        test_frame_issue();
        test_debounce();
        test_simultaneous();
        test_withhold();
        test_reset_mid();
        test_spurious();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
